// File: rtl/router_src_arb_if.sv
// Source-side and router-side signal bundle for router_src_arb.
// Handshake: rtr_busy=1 from the router stalls the byte on rtr_data; a source byte is
// consumed on the rising edge that ends a cycle with src_pop[i]=1, and the source
// shows its next byte from the following cycle on.
interface router_src_arb_if;
    logic [2:0]  src_req;
    logic [23:0] src_data;
    logic [2:0]  src_pop;
    logic        rtr_busy;
    logic [7:0]  rtr_data;
    logic        rtr_pkt_valid;
    logic [2:0]  grant;
    logic        drop_pulse;
    logic [2:0]  dbg_state;

    modport slave (
        input  src_req, src_data, rtr_busy,
        output src_pop, rtr_data, rtr_pkt_valid, grant, drop_pulse, dbg_state
    );

    modport master (
        output src_req, src_data, rtr_busy,
        input  src_pop, rtr_data, rtr_pkt_valid, grant, drop_pulse, dbg_state
    );
endinterface

// File: rtl/router_src_arb.sv
// Three-source round-robin front end for one router input: forwards header and payload,
// appends an XOR parity byte, flushes packets addressed to 2'b11, then idles a gap.
module router_src_arb #(
    parameter int GAP_CYCLES = 2  // legal range 1..15
) (
    input  logic            clock,
    input  logic            reset,
    router_src_arb_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PARITY  = 3'd3,
        S_FLUSH   = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_grant;
    logic [1:0] r_last;
    logic [5:0] r_cnt;
    logic [7:0] r_parity;
    logic [3:0] r_gap;
    logic       r_drop;

    logic [7:0] w_byte;
    logic       w_drop_hdr;
    logic       w_pop_en;
    logic [1:0] w_first;
    logic [1:0] w_second;
    logic [1:0] w_third;
    logic [1:0] w_pick_idx;
    logic [2:0] w_pick_oh;
    logic       w_any_req;

    always_comb begin
        case (r_grant)
            3'b010:  w_byte = bus.src_data[15:8];
            3'b100:  w_byte = bus.src_data[23:16];
            default: w_byte = bus.src_data[7:0];
        endcase
    end

    assign w_drop_hdr = (r_state == S_HDR) && (w_byte[1:0] == 2'b11);

    // Search starts just after the last granted index on the ring 0->1->2->0.
    always_comb begin
        case (r_last)
            2'd0: begin
                w_first  = 2'd1;
                w_second = 2'd2;
                w_third  = 2'd0;
            end
            2'd1: begin
                w_first  = 2'd2;
                w_second = 2'd0;
                w_third  = 2'd1;
            end
            default: begin
                w_first  = 2'd0;
                w_second = 2'd1;
                w_third  = 2'd2;
            end
        endcase
        if (bus.src_req[w_first]) begin
            w_pick_idx = w_first;
        end else if (bus.src_req[w_second]) begin
            w_pick_idx = w_second;
        end else begin
            w_pick_idx = w_third;
        end
    end

    assign w_any_req = |bus.src_req;
    assign w_pick_oh = 3'b001 << w_pick_idx;

    // Reset gates the pop so an aborted packet never consumes another source byte.
    always_comb begin
        w_pop_en = 1'b0;
        case (r_state)
            S_HDR:     w_pop_en = w_drop_hdr || !bus.rtr_busy;
            S_PAYLOAD: w_pop_en = !bus.rtr_busy;
            S_FLUSH:   w_pop_en = 1'b1;
            default:   w_pop_en = 1'b0;
        endcase
        if (reset) begin
            w_pop_en = 1'b0;
        end
    end

    always_comb begin
        bus.rtr_data      = 8'h00;
        bus.rtr_pkt_valid = 1'b0;
        case (r_state)
            S_HDR: begin
                if (!w_drop_hdr) begin
                    bus.rtr_data      = w_byte;
                    bus.rtr_pkt_valid = 1'b1;
                end
            end
            S_PAYLOAD: begin
                bus.rtr_data      = w_byte;
                bus.rtr_pkt_valid = 1'b1;
            end
            S_PARITY: bus.rtr_data = r_parity;
            default: begin
                bus.rtr_data      = 8'h00;
                bus.rtr_pkt_valid = 1'b0;
            end
        endcase
    end

    assign bus.src_pop    = w_pop_en ? r_grant : 3'b000;
    assign bus.grant      = r_grant;
    assign bus.drop_pulse = r_drop;
    assign bus.dbg_state  = r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= 3'b000;
            r_last   <= 2'd2;
            r_cnt    <= 6'd0;
            r_parity <= 8'h00;
            r_gap    <= 4'd0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_pick_oh;
                        r_last  <= w_pick_idx;
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_drop_hdr) begin
                        r_cnt <= w_byte[7:2];
                        if (w_byte[7:2] == 6'd0) begin
                            r_drop  <= 1'b1;
                            r_gap   <= GAP_LOAD;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_FLUSH;
                        end
                    end else if (!bus.rtr_busy) begin
                        r_cnt    <= w_byte[7:2];
                        r_parity <= w_byte;
                        r_state  <= (w_byte[7:2] == 6'd0) ? S_PARITY : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!bus.rtr_busy) begin
                        r_parity <= r_parity ^ w_byte;
                        if (r_cnt != 6'd0) begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                        if (r_cnt <= 6'd1) begin
                            r_state <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (!bus.rtr_busy) begin
                        r_gap   <= GAP_LOAD;
                        r_state <= S_GAP;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt != 6'd0) begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                    if (r_cnt <= 6'd1) begin
                        r_drop  <= 1'b1;
                        r_gap   <= GAP_LOAD;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == 4'd0) begin
                        r_grant <= 3'b000;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: begin
                    r_grant <= 3'b000;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_src_arb.sv
// Bench for router_src_arb: byte-stream sources, router-side scoreboard, vector table
// plus hand sequences for backpressure, fairness and mid-packet reset.
module tb_router_src_arb;

    localparam int GAP = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    router_src_arb_if bus ();

    router_src_arb #(.GAP_CYCLES(GAP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         src;
        logic [7:0] hdr;
        logic [7:0] seed;
        logic [2:0] exp_grant;
        int         exp_pops;
        int         exp_drops;
        logic       busy_rand;
    } vec_t;

    vec_t       vt [7];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] src_mem [3][256];
    int         src_ptr [3];
    int         src_len [3];
    logic [2:0] pend_pop = 3'b000;
    logic [8:0] exp_q [$];
    logic [2:0] got_grant_q [$];
    int         grant_cyc_q [$];
    int         pop_cnt [3];
    int         drop_cnt = 0;
    logic       parity_due = 1'b0;
    logic [2:0] prev_grant = 3'b000;
    logic [8:0] mon_byte;
    logic       rand_busy_en = 1'b0;
    logic       busy_force = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic drive_src();
        logic [23:0] d;
        logic [2:0]  r;
        d = '0;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            if (src_ptr[i] < src_len[i]) begin
                r[i] = 1'b1;
                d[i*8 +: 8] = src_mem[i][src_ptr[i]];
            end
        end
        bus.src_req  = r;
        bus.src_data = d;
    endtask

    // Append one packet to a source and queue the router bytes it should produce.
    task automatic load_pkt(input int s, input logic [7:0] hdr, input logic [7:0] seed);
        int         n;
        logic [7:0] b;
        logic [7:0] par;
        logic       fwd;
        n   = int'(hdr[7:2]);
        fwd = (hdr[1:0] != 2'b11);
        src_mem[s][src_len[s]] = hdr;
        par = hdr;
        if (fwd) exp_q.push_back({1'b1, hdr});
        for (int k = 0; k < n; k++) begin
            b = seed + 8'(k * 17);
            src_mem[s][src_len[s] + 1 + k] = b;
            par = par ^ b;
            if (fwd) exp_q.push_back({1'b1, b});
        end
        if (fwd) exp_q.push_back({1'b0, par});
        src_len[s] = src_len[s] + n + 1;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 600) begin
            @(negedge clock);
            n++;
            done = (src_ptr[0] >= src_len[0]) && (src_ptr[1] >= src_len[1]) &&
                   (src_ptr[2] >= src_len[2]) && (exp_q.size() == 0) && (bus.grant == 3'b000);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: timed out after %0d cycles", name, n);
        end
    endtask

    task automatic wait_byte(input string name, input logic [7:0] b);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clock);
            n++;
            seen = bus.rtr_pkt_valid && (bus.rtr_data == b);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: byte %h never presented", name, b);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) pop_cnt[i] = 0;
        drop_cnt = 0;
        got_grant_q.delete();
        grant_cyc_q.delete();
    endtask

    // Source model and router-busy driver, updated just after each rising edge.
    always @(posedge clock) begin
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (pend_pop[i] && (src_ptr[i] < src_len[i])) src_ptr[i]++;
        end
        drive_src();
        bus.rtr_busy = rand_busy_en ? ($urandom_range(0, 3) == 0) : busy_force;
    end

    // Monitor: a router byte is taken on any non-busy cycle with pkt_valid high, and the
    // parity byte is the first non-busy cycle with pkt_valid low after such a byte.
    always @(negedge clock) begin
        if (reset) begin
            pend_pop   = 3'b000;
            parity_due = 1'b0;
            prev_grant = 3'b000;
        end else begin
            pend_pop = bus.src_pop;
            if (bus.src_pop != 3'b000) begin
                check("pop_onehot", $countones(bus.src_pop), 1);
                for (int i = 0; i < 3; i++) begin
                    if (bus.src_pop[i]) pop_cnt[i]++;
                end
            end
            if (bus.drop_pulse) drop_cnt++;
            if ((bus.grant != 3'b000) && (prev_grant == 3'b000)) begin
                got_grant_q.push_back(bus.grant);
                grant_cyc_q.push_back(cyc);
            end
            prev_grant = bus.grant;
            if (!bus.rtr_busy && (bus.rtr_pkt_valid || parity_due)) begin
                mon_byte   = {bus.rtr_pkt_valid, bus.rtr_data};
                parity_due = bus.rtr_pkt_valid;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rtr_byte: got %h, none expected", mon_byte);
                end else begin
                    check("rtr_byte", mon_byte, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] fair_exp [6];

        vt[0] = '{0, 8'h0D, 8'h11, 3'b001, 4,  0, 1'b0};
        vt[1] = '{1, 8'h00, 8'h00, 3'b010, 1,  0, 1'b0};
        vt[2] = '{2, 8'h0B, 8'h77, 3'b100, 3,  1, 1'b1};
        vt[3] = '{2, 8'h03, 8'h00, 3'b100, 1,  1, 1'b0};
        vt[4] = '{1, 8'h16, 8'hA5, 3'b010, 6,  0, 1'b1};
        vt[5] = '{0, 8'hFD, 8'h03, 3'b001, 64, 0, 1'b1};
        vt[6] = '{2, 8'h06, 8'h5A, 3'b100, 2,  0, 1'b1};
        fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        for (int i = 0; i < 3; i++) begin
            src_ptr[i] = 0;
            src_len[i] = 0;
            pop_cnt[i] = 0;
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_grant", bus.grant, 3'b000);
        check("rst_data", bus.rtr_data, 8'h00);
        check("rst_pkt_valid", bus.rtr_pkt_valid, 1'b0);
        check("rst_pop", bus.src_pop, 3'b000);
        check("rst_drop", bus.drop_pulse, 1'b0);
        check("rst_state", bus.dbg_state, 3'd0);
        #1 reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            clear_counts();
            rand_busy_en = vt[v].busy_rand;
            load_pkt(vt[v].src, vt[v].hdr, vt[v].seed);
            wait_done($sformatf("v%0d_done", v));
            rand_busy_en = 1'b0;
            check($sformatf("v%0d_pops", v), pop_cnt[0] + pop_cnt[1] + pop_cnt[2], vt[v].exp_pops);
            check($sformatf("v%0d_src_pops", v), pop_cnt[vt[v].src], vt[v].exp_pops);
            check($sformatf("v%0d_drops", v), drop_cnt, vt[v].exp_drops);
            check($sformatf("v%0d_grants", v), got_grant_q.size(), 1);
            if (got_grant_q.size() > 0) check($sformatf("v%0d_grant", v), got_grant_q[0], vt[v].exp_grant);
        end

        // All three sources request continuously with two length-1 packets each.
        clear_counts();
        load_pkt(0, 8'h05, 8'hA0);
        load_pkt(1, 8'h04, 8'hB0);
        load_pkt(2, 8'h06, 8'hC0);
        load_pkt(0, 8'h05, 8'hA1);
        load_pkt(1, 8'h04, 8'hB1);
        load_pkt(2, 8'h06, 8'hC1);
        wait_done("fair_done");
        check("fair_grants", got_grant_q.size(), 6);
        if (got_grant_q.size() == 6) begin
            for (int k = 0; k < 6; k++) check($sformatf("fair_grant%0d", k), got_grant_q[k], fair_exp[k]);
            // header + payload + parity + GAP cycles + one arbitration cycle
            for (int k = 1; k < 6; k++)
                check($sformatf("fair_spacing%0d", k), grant_cyc_q[k] - grant_cyc_q[k-1], 4 + GAP);
        end

        // Router busy for three cycles while the second payload byte is presented.
        clear_counts();
        load_pkt(0, 8'h0D, 8'h11);
        wait_byte("bp_wait", 8'h11);
        busy_force = 1'b1;
        @(negedge clock);
        check("bp_data0", bus.rtr_data, 8'h22);
        check("bp_pop0", bus.src_pop, 3'b000);
        @(negedge clock);
        check("bp_data1", bus.rtr_data, 8'h22);
        check("bp_pop1", bus.src_pop, 3'b000);
        @(negedge clock);
        check("bp_data2", bus.rtr_data, 8'h22);
        check("bp_pop2", bus.src_pop, 3'b000);
        check("bp_valid", bus.rtr_pkt_valid, 1'b1);
        busy_force = 1'b0;
        wait_done("bp_done");
        check("bp_pops", pop_cnt[0], 4);

        // Reset in the middle of a payload from source 0; afterwards 0 must win over 1.
        clear_counts();
        load_pkt(0, 8'h0D, 8'h40);
        wait_byte("rst_wait", 8'h40);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_ptr[i] = 0;
            src_len[i] = 0;
        end
        #1;
        check("rst_pop_gated", bus.src_pop, 3'b000);
        @(negedge clock);
        check("rstmid_grant", bus.grant, 3'b000);
        check("rstmid_data", bus.rtr_data, 8'h00);
        check("rstmid_valid", bus.rtr_pkt_valid, 1'b0);
        check("rstmid_pop", bus.src_pop, 3'b000);
        check("rstmid_drop", bus.drop_pulse, 1'b0);
        check("rstmid_state", bus.dbg_state, 3'd0);
        check("rstmid_pops", pop_cnt[0], 2);
        exp_q.delete();
        #1 reset = 1'b0;
        clear_counts();
        load_pkt(0, 8'h09, 8'h70);
        load_pkt(1, 8'h0D, 8'h60);
        wait_done("post_rst_done");
        check("post_rst_grants", got_grant_q.size(), 2);
        if (got_grant_q.size() == 2) begin
            check("post_rst_first", got_grant_q[0], 3'b001);
            check("post_rst_second", got_grant_q[1], 3'b010);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
